// File: rtl/filter_pad_sequencer.sv
// Feeds one frame into the 2-D kernel filter as a zero-padded raster stream,
// then keeps the filter clocked with flush beats until it reports done.
module filter_pad_sequencer #(
   parameter int width      = 1920,
   parameter int height     = 1080,
   parameter int kernelSize = 7
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        iStart,
   input  logic        iValid,
   input  logic [23:0] iData,
   output logic        oReady,
   output logic        oValid,
   output logic [23:0] oData,
   output logic        oPad,
   input  logic        iFilterDone,
   output logic        oBusy,
   output logic        oFrameDone,
   output logic [31:0] oOutCnt
);

   localparam int B       = (kernelSize - 1) / 2;
   localparam int WP      = width + 2 * B;
   localparam int COL_MAX = (WP > width) ? WP : width;
   localparam int COL_W   = $clog2(COL_MAX + 1);
   localparam int ROW_W   = (height > 1) ? $clog2(height) : 1;
   localparam int PAD_W   = (B > 1) ? $clog2(B) : 1;

   localparam logic [COL_W-1:0] WP_LAST    = COL_W'(WP - 1);
   localparam logic [COL_W-1:0] WIDTH_LAST = COL_W'(width - 1);
   localparam logic [COL_W-1:0] B_LAST     = COL_W'((B > 0) ? B - 1 : 0);
   localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(height - 1);
   localparam logic [PAD_W-1:0] PAD_LAST   = PAD_W'((B > 0) ? B - 1 : 0);

   typedef enum logic [2:0] {
      IDLE,
      TOP,
      ROW_L,
      ROW_D,
      ROW_R,
      BOT,
      FLUSH,
      DONE
   } state_t;

   state_t            state_q;
   logic [COL_W-1:0]  col_q;
   logic [ROW_W-1:0]  row_q;
   logic [PAD_W-1:0]  padRow_q;
   logic              valid_q;
   logic [23:0]       data_q;
   logic              pad_q;
   logic              frameDone_q;
   logic [31:0]       outCnt_q;

   logic              beatValid_d;
   logic [23:0]       beatData_d;
   logic              beatPad_d;
   logic              beatCount_d;

   // Beat produced by the current state; flush beats are valid but never counted.
   always_comb begin
      beatValid_d = 1'b0;
      beatData_d  = '0;
      beatPad_d   = 1'b0;
      beatCount_d = 1'b0;
      case (state_q)
         TOP, ROW_L, ROW_R, BOT: begin
            beatValid_d = 1'b1;
            beatPad_d   = 1'b1;
            beatCount_d = 1'b1;
         end
         ROW_D: begin
            if (iValid) begin
               beatValid_d = 1'b1;
               beatData_d  = iData;
               beatCount_d = 1'b1;
            end
         end
         FLUSH: begin
            beatValid_d = 1'b1;
            beatPad_d   = 1'b1;
         end
         default: ;
      endcase
   end

   // Frame sequencer: col walks each segment, padRow walks the top/bottom bands.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         col_q       <= '0;
         row_q       <= '0;
         padRow_q    <= '0;
         valid_q     <= 1'b0;
         data_q      <= '0;
         pad_q       <= 1'b0;
         frameDone_q <= 1'b0;
         outCnt_q    <= '0;
      end else begin
         valid_q     <= beatValid_d;
         data_q      <= beatData_d;
         pad_q       <= beatPad_d;
         frameDone_q <= 1'b0;
         if (beatCount_d) begin
            outCnt_q <= outCnt_q + 32'd1;
         end
         case (state_q)
            IDLE: begin
               if (iStart) begin
                  outCnt_q <= '0;
                  col_q    <= '0;
                  row_q    <= '0;
                  padRow_q <= '0;
                  state_q  <= (B == 0) ? ROW_D : TOP;
               end
            end
            TOP: begin
               if (col_q == WP_LAST) begin
                  col_q <= '0;
                  if (padRow_q == PAD_LAST) begin
                     padRow_q <= '0;
                     state_q  <= ROW_L;
                  end else begin
                     padRow_q <= padRow_q + 1'b1;
                  end
               end else begin
                  col_q <= col_q + 1'b1;
               end
            end
            ROW_L: begin
               if (col_q == B_LAST) begin
                  col_q   <= '0;
                  state_q <= ROW_D;
               end else begin
                  col_q <= col_q + 1'b1;
               end
            end
            ROW_D: begin
               if (iValid) begin
                  if (col_q == WIDTH_LAST) begin
                     col_q <= '0;
                     if (B > 0) begin
                        state_q <= ROW_R;
                     end else if (row_q == ROW_LAST) begin
                        row_q   <= '0;
                        state_q <= FLUSH;
                     end else begin
                        row_q <= row_q + 1'b1;
                     end
                  end else begin
                     col_q <= col_q + 1'b1;
                  end
               end
            end
            ROW_R: begin
               if (col_q == B_LAST) begin
                  col_q <= '0;
                  if (row_q == ROW_LAST) begin
                     row_q   <= '0;
                     state_q <= BOT;
                  end else begin
                     row_q   <= row_q + 1'b1;
                     state_q <= ROW_L;
                  end
               end else begin
                  col_q <= col_q + 1'b1;
               end
            end
            BOT: begin
               if (col_q == WP_LAST) begin
                  col_q <= '0;
                  if (padRow_q == PAD_LAST) begin
                     padRow_q <= '0;
                     state_q  <= FLUSH;
                  end else begin
                     padRow_q <= padRow_q + 1'b1;
                  end
               end else begin
                  col_q <= col_q + 1'b1;
               end
            end
            FLUSH: begin
               if (iFilterDone) begin
                  frameDone_q <= 1'b1;
                  state_q     <= DONE;
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // Upstream handshake depends on the state register alone, never on iValid.
   assign oReady     = (state_q == ROW_D);
   assign oBusy      = (state_q != IDLE);
   assign oValid     = valid_q;
   assign oData      = data_q;
   assign oPad       = pad_q;
   assign oFrameDone = frameDone_q;
   assign oOutCnt    = outCnt_q;

endmodule

// File: tb/tb_filter_pad_sequencer.sv
// Bench for filter_pad_sequencer: a bordered 4x3 instance and a border-free one,
// compared against the padded frame built directly from pixel coordinates.
module tb_filter_pad_sequencer;

   localparam int W  = 4;
   localparam int H  = 3;
   localparam int B  = 1;
   localparam int WP = W + 2 * B;
   localparam int NB = (H + 2 * B) * WP;

   logic        clk = 1'b0;
   logic        reset;
   logic        iStart, iValid, iFilterDone;
   logic [23:0] iData;
   logic        oReady, oValid, oPad, oBusy, oFrameDone;
   logic [23:0] oData;
   logic [31:0] oOutCnt;

   logic        start1, valid1, done1;
   logic [23:0] data1;
   logic        ready1, oValid1, oPad1, oBusy1, oFrameDone1;
   logic [23:0] oData1;
   logic [31:0] oOutCnt1;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   filter_pad_sequencer #(.width(W), .height(H), .kernelSize(3)) u_dut (
      .clk(clk), .reset(reset), .iStart(iStart), .iValid(iValid), .iData(iData),
      .oReady(oReady), .oValid(oValid), .oData(oData), .oPad(oPad),
      .iFilterDone(iFilterDone), .oBusy(oBusy), .oFrameDone(oFrameDone), .oOutCnt(oOutCnt)
   );

   filter_pad_sequencer #(.width(W), .height(H), .kernelSize(1)) u_dut1 (
      .clk(clk), .reset(reset), .iStart(start1), .iValid(valid1), .iData(data1),
      .oReady(ready1), .oValid(oValid1), .oData(oData1), .oPad(oPad1),
      .iFilterDone(done1), .oBusy(oBusy1), .oFrameDone(oFrameDone1), .oOutCnt(oOutCnt1)
   );

   // One frame on the bordered instance. mode 0: iValid held, 1: toggled, 2: random.
   task automatic run_frame(input int mode, input int flushWait, input bit poke);
      logic [23:0] src[$];
      logic [23:0] expData[$];
      bit          expPad[$];
      int srcIdx = 0, beats = 0, readyCycles = 0, cyc = 0, k = 0;
      bit gapPending = 0, rowEndPending = 0, poked = 0;
      for (int i = 0; i < W * H; i++) src.push_back(24'($urandom));
      for (int r = 0; r < H + 2 * B; r++) begin
         for (int c = 0; c < WP; c++) begin
            if (r < B || r >= B + H || c < B || c >= B + W) begin
               expData.push_back(24'h0);
               expPad.push_back(1'b1);
            end else begin
               expData.push_back(src[k]);
               expPad.push_back(1'b0);
               k++;
            end
         end
      end
      @(negedge clk); iStart = 1'b1;
      @(negedge clk); iStart = 1'b0;
      while (beats < NB && cyc < 400) begin
         if (gapPending) begin
            tests++;
            if (oValid !== 1'b0) begin
               fails++; $display("[TB] FAIL gap_no_beat: oValid=%b expected 0", oValid);
            end
         end
         if (rowEndPending) begin
            tests++;
            if (oReady !== 1'b0) begin
               fails++; $display("[TB] FAIL row_end_ready: oReady=%b expected 0", oReady);
            end
         end
         if (mode == 0 && beats > 0) begin
            tests++;
            if (oValid !== 1'b1) begin
               fails++; $display("[TB] FAIL contiguous beat%0d: oValid=%b expected 1", beats, oValid);
            end
         end
         if (oValid === 1'b1) begin
            tests++;
            if (oData !== expData[beats] || oPad !== expPad[beats]) begin
               fails++;
               $display("[TB] FAIL beat%0d: data/pad got %h/%b expected %h/%b",
                        beats, oData, oPad, expData[beats], expPad[beats]);
            end
            beats++;
            if (beats == NB) begin
               tests++;
               if (oOutCnt !== 32'(NB)) begin
                  fails++; $display("[TB] FAIL outcnt_flush_entry: got %0d expected %0d", oOutCnt, NB);
               end
            end
         end
         iValid = (mode == 0) ? 1'b1 : (mode == 1) ? ((cyc % 2) == 0) : 1'($urandom_range(0, 1));
         iData  = (srcIdx < W * H) ? src[srcIdx] : 24'hA5A5A5;
         iStart = (poke && !poked && oReady === 1'b1);
         if (iStart) poked = 1'b1;
         gapPending    = (oReady === 1'b1) && !iValid;
         rowEndPending = (oReady === 1'b1) && iValid && (((srcIdx + 1) % W) == 0);
         if (oReady === 1'b1) readyCycles++;
         if (oReady === 1'b1 && iValid) srcIdx++;
         cyc++;
         @(negedge clk);
      end
      iValid = 1'b0;
      iStart = 1'b0;
      tests++;
      if (beats != NB) begin
         fails++; $display("[TB] FAIL frame_timeout: beats=%0d expected %0d", beats, NB);
      end
      if (mode == 0) begin
         tests++;
         if (readyCycles != W * H) begin
            fails++; $display("[TB] FAIL ready_cycles: got %0d expected %0d", readyCycles, W * H);
         end
      end
      for (int i = 0; i < flushWait; i++) begin
         tests++;
         if (oValid !== 1'b1 || oData !== 24'h0 || oPad !== 1'b1 || oOutCnt !== 32'(NB)) begin
            fails++;
            $display("[TB] FAIL flush%0d: valid/data/pad/cnt got %b/%h/%b/%0d expected 1/0/1/%0d",
                     i, oValid, oData, oPad, oOutCnt, NB);
         end
         iStart = (poke && i == 2);
         @(negedge clk);
      end
      iStart = 1'b0;
      iFilterDone = 1'b1;
      @(negedge clk);
      iFilterDone = 1'b0;
      tests++;
      if (oFrameDone !== 1'b1 || oBusy !== 1'b1) begin
         fails++; $display("[TB] FAIL frame_done: done/busy got %b/%b expected 1/1", oFrameDone, oBusy);
      end
      @(negedge clk);
      tests++;
      if (oFrameDone !== 1'b0 || oBusy !== 1'b0 || oOutCnt !== 32'(NB)) begin
         fails++;
         $display("[TB] FAIL after_done: done/busy/cnt got %b/%b/%0d expected 0/0/%0d",
                  oFrameDone, oBusy, oOutCnt, NB);
      end
   endtask

   task automatic test_reset();
      #3;
      tests++;
      if (oValid !== 1'b0 || oPad !== 1'b0 || oData !== 24'h0 || oReady !== 1'b0) begin
         fails++; $display("[TB] FAIL reset_outputs: valid/pad/data/ready got %b/%b/%h/%b expected 0/0/0/0",
                           oValid, oPad, oData, oReady);
      end
      tests++;
      if (oBusy !== 1'b0 || oFrameDone !== 1'b0 || oOutCnt !== 32'd0) begin
         fails++; $display("[TB] FAIL reset_status: busy/done/cnt got %b/%b/%0d expected 0/0/0",
                           oBusy, oFrameDone, oOutCnt);
      end
      tests++;
      if (oBusy1 !== 1'b0 || oOutCnt1 !== 32'd0 || oValid1 !== 1'b0) begin
         fails++; $display("[TB] FAIL reset_nb: busy/cnt/valid got %b/%0d/%b expected 0/0/0",
                           oBusy1, oOutCnt1, oValid1);
      end
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_held_and_flush();
      run_frame(0, 20, 1'b0);
   endtask

   task automatic test_toggle_valid();
      run_frame(1, 4, 1'b0);
   endtask

   task automatic test_async_reset();
      int waitCyc = 0;
      @(negedge clk); iStart = 1'b1;
      @(negedge clk); iStart = 1'b0; iValid = 1'b1; iData = 24'h123456;
      while (oReady !== 1'b1 && waitCyc < 50) begin
         waitCyc++;
         @(negedge clk);
      end
      tests++;
      if (oReady !== 1'b1) begin
         fails++; $display("[TB] FAIL reach_row_data: oReady=%b expected 1", oReady);
      end
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      tests++;
      if (oValid !== 1'b0 || oReady !== 1'b0 || oBusy !== 1'b0 || oOutCnt !== 32'd0) begin
         fails++; $display("[TB] FAIL async_reset: valid/ready/busy/cnt got %b/%b/%b/%0d expected 0/0/0/0",
                           oValid, oReady, oBusy, oOutCnt);
      end
      iValid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         tests++;
         if (oFrameDone !== 1'b0 || oBusy !== 1'b0) begin
            fails++; $display("[TB] FAIL reset_hold%0d: done/busy got %b/%b expected 0/0", i, oFrameDone, oBusy);
         end
      end
      reset = 1'b1;
      @(negedge clk);
      run_frame(0, 5, 1'b0);
   endtask

   task automatic test_start_ignored();
      run_frame(0, 6, 1'b1);
   endtask

   task automatic test_random_valid();
      run_frame(2, 3, 1'b0);
   endtask

   task automatic test_no_border();
      logic [23:0] src[$];
      int beats = 0, srcIdx = 0, cyc = 0;
      for (int i = 0; i < W * H; i++) src.push_back(24'($urandom));
      @(negedge clk); start1 = 1'b1;
      @(negedge clk); start1 = 1'b0;
      while (beats < W * H && cyc < 200) begin
         if (oValid1 === 1'b1) begin
            tests++;
            if (oData1 !== src[beats] || oPad1 !== 1'b0) begin
               fails++; $display("[TB] FAIL nb_beat%0d: data/pad got %h/%b expected %h/0",
                                 beats, oData1, oPad1, src[beats]);
            end
            beats++;
            if (beats == W * H) begin
               tests++;
               if (oOutCnt1 !== 32'(W * H)) begin
                  fails++; $display("[TB] FAIL nb_outcnt: got %0d expected %0d", oOutCnt1, W * H);
               end
            end
         end
         valid1 = 1'($urandom_range(0, 1));
         data1  = (srcIdx < W * H) ? src[srcIdx] : 24'h5A5A5A;
         if (ready1 === 1'b1 && valid1) srcIdx++;
         cyc++;
         @(negedge clk);
      end
      valid1 = 1'b0;
      tests++;
      if (beats != W * H) begin
         fails++; $display("[TB] FAIL nb_timeout: beats=%0d expected %0d", beats, W * H);
      end
      tests++;
      if (oValid1 !== 1'b1 || oPad1 !== 1'b1 || oData1 !== 24'h0) begin
         fails++; $display("[TB] FAIL nb_flush: valid/pad/data got %b/%b/%h expected 1/1/0",
                           oValid1, oPad1, oData1);
      end
      done1 = 1'b1;
      @(negedge clk);
      done1 = 1'b0;
      tests++;
      if (oFrameDone1 !== 1'b1) begin
         fails++; $display("[TB] FAIL nb_frame_done: got %b expected 1", oFrameDone1);
      end
      @(negedge clk);
      tests++;
      if (oBusy1 !== 1'b0 || oOutCnt1 !== 32'(W * H)) begin
         fails++; $display("[TB] FAIL nb_idle: busy/cnt got %b/%0d expected 0/%0d", oBusy1, oOutCnt1, W * H);
      end
   endtask

   initial begin
      reset = 1'b0;
      iStart = 1'b0; iValid = 1'b0; iData = '0; iFilterDone = 1'b0;
      start1 = 1'b0; valid1 = 1'b0; data1 = '0; done1 = 1'b0;
      test_reset();
      test_held_and_flush();
      test_toggle_valid();
      test_async_reset();
      test_start_ignored();
      test_random_valid();
      test_no_border();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
